// File: rtl/flag_xfer_arbiter_pkg.sv
// rtl/flag_xfer_arbiter_pkg.sv - shared state encoding and counter width for the flag transfer arbiter
package flag_xfer_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int TMO_W = 16;

endpackage

// File: rtl/flag_xfer_arbiter_rr_pick.sv
// rtl/flag_xfer_arbiter_rr_pick.sv - combinational round-robin pick of the first pending index after ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int SELW = 2
) (
  input  logic [NREQ-1:0] pending,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            valid
);

  logic [SELW-1:0] idx;

  // Scan starts one past the last grant, so ptr itself is checked last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = SELW'((int'(ptr) + i) % NREQ);
      if (!valid && pending[idx]) begin
        valid = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/flag_xfer_arbiter.sv
// rtl/flag_xfer_arbiter.sv - round-robin scheduler for one clkA->clkB flag crossing with ack and timeout
// Optional saturating merge/timeout/spurious-ack counters when FLAG_XFER_STATS_EN is defined.
module flag_xfer_arbiter
  import flag_xfer_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int SELW    = 2,
  parameter int MIN_GAP = 4,
  parameter int TMO     = 255
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_ack,
  output logic            o_flag,
  output logic [SELW-1:0] o_sel,
  output logic            o_busy,
  output logic [NREQ-1:0] o_pending,
  output logic [NREQ-1:0] o_done,
  output logic            o_timeout
`ifdef FLAG_XFER_STATS_EN
  ,
  output logic [7:0]      o_merge_cnt,
  output logic [7:0]      o_tmo_cnt,
  output logic [7:0]      o_spur_cnt
`endif
);

  state_t            state;
  logic [TMO_W-1:0]  timer;
  logic [SELW-1:0]   rrPtr;
  logic [SELW-1:0]   pick;
  logic              pickValid;
  logic              ackHit;
  logic              tmoHit;
  logic [NREQ-1:0]   selMask;
  logic [NREQ-1:0]   clrMask;

  rr_pick #(.NREQ(NREQ), .SELW(SELW)) uPick (
    .pending (o_pending),
    .ptr     (rrPtr),
    .grant   (pick),
    .valid   (pickValid)
  );

  // Ack beats expiry when both land in the same WAIT cycle.
  always_comb begin
    selMask        = '0;
    selMask[o_sel] = 1'b1;
    ackHit         = (state == S_WAIT) && i_ack;
    tmoHit         = (state == S_WAIT) && !i_ack && (timer == TMO_W'(TMO - 1));
    clrMask        = (ackHit || tmoHit) ? selMask : '0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= S_IDLE;
      timer     <= '0;
      rrPtr     <= SELW'(NREQ - 1);
      o_flag    <= 1'b0;
      o_sel     <= '0;
      o_busy    <= 1'b0;
      o_pending <= '0;
      o_done    <= '0;
      o_timeout <= 1'b0;
    end else begin
      // A request in the clearing cycle starts a fresh transaction.
      o_pending <= (o_pending & ~clrMask) | i_req;
      o_flag    <= 1'b0;
      o_done    <= '0;
      o_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pickValid) begin
            o_sel  <= pick;
            rrPtr  <= pick;
            o_flag <= 1'b1;
            o_busy <= 1'b1;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (ackHit) begin
            o_done <= selMask;
            timer  <= '0;
            state  <= S_GAP;
          end else if (tmoHit) begin
            o_timeout <= 1'b1;
            timer     <= '0;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          // The timer doubles as the spacing counter between transactions.
          if (timer == TMO_W'(MIN_GAP - 1)) begin
            timer  <= '0;
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FLAG_XFER_STATS_EN
  logic [NREQ-1:0] mergeMask;
  logic [8:0]      mergeSum;

  always_comb begin
    mergeMask = i_req & o_pending & ~clrMask;
    mergeSum  = {1'b0, o_merge_cnt} + 9'($countones(mergeMask));
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_merge_cnt <= '0;
      o_tmo_cnt   <= '0;
      o_spur_cnt  <= '0;
    end else begin
      o_merge_cnt <= mergeSum[8] ? 8'hFF : mergeSum[7:0];
      if (tmoHit && o_tmo_cnt != 8'hFF)
        o_tmo_cnt <= o_tmo_cnt + 8'd1;
      if (i_ack && state != S_WAIT && o_spur_cnt != 8'hFF)
        o_spur_cnt <= o_spur_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flag_xfer_arbiter.sv
// tb/tb_flag_xfer_arbiter.sv - directed scoreboard bench for flag_xfer_arbiter (NREQ=4, MIN_GAP=4, TMO=8)
module tb_flag_xfer_arbiter;

  localparam int NREQ    = 4;
  localparam int SELW    = 2;
  localparam int MIN_GAP = 4;
  localparam int TMO     = 8;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NREQ-1:0] req;
  logic            ack;
  logic            flag;
  logic [SELW-1:0] sel;
  logic            busy;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] done;
  logic            tmo;
`ifdef FLAG_XFER_STATS_EN
  logic [7:0]      mergeCnt;
  logic [7:0]      tmoCnt;
  logic [7:0]      spurCnt;
`endif

  int nTests = 0;
  int nFail  = 0;
  int cyc    = 0;
  int lastFlag = -1;
  logic [SELW-1:0] expQ[$];

  flag_xfer_arbiter #(.NREQ(NREQ), .SELW(SELW), .MIN_GAP(MIN_GAP), .TMO(TMO)) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_req     (req),
    .i_ack     (ack),
    .o_flag    (flag),
    .o_sel     (sel),
    .o_busy    (busy),
    .o_pending (pending),
    .o_done    (done),
    .o_timeout (tmo)
`ifdef FLAG_XFER_STATS_EN
    ,
    .o_merge_cnt (mergeCnt),
    .o_tmo_cnt   (tmoCnt),
    .o_spur_cnt  (spurCnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitFlag(input string tag);
    int n = 0;
    while (flag !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_flag"}, 32'(flag), 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic doReset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // Scoreboard: expected grant order vs each observed o_flag, plus pulse spacing.
  always @(negedge clk) begin
    if (rstn !== 1'b1) begin
      lastFlag = -1;
    end else if (flag === 1'b1) begin
      check("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0)
        check("sb_sel", 32'(sel), 32'(expQ.pop_front()));
      if (lastFlag >= 0)
        check("flag_spacing", 32'((cyc - lastFlag) >= MIN_GAP + 3), 32'd1);
      lastFlag = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [NREQ-1:0] doneSeen;
    logic            flagSeen;

    rstn = 1'b0;
    req  = '0;
    ack  = 1'b0;
    #1;
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // 1: single request, ack three cycles after flag
    req = 4'b0001;
    expQ.push_back(2'd0);
    tick();
    req = '0;
    check("t1_pending", 32'(pending), 32'h1);
    check("t1_noflag_yet", 32'(flag), 32'd0);
    tick();
    check("t1_flag_latency", 32'(flag), 32'd1);
    tick();
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t1_done", 32'(done), 32'h1);
    check("t1_pending_clr", 32'(pending), 32'h0);
    tick();
    tick();
    tick();
    check("t1_busy_in_gap", 32'(busy), 32'd1);
    tick();
    check("t1_busy_low", 32'(busy), 32'd0);

    // 2: all four at once from reset, granted 0,1,2,3
    doReset();
    tick();
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) expQ.push_back(SELW'(k));
    tick();
    req = '0;
    for (int k = 0; k < NREQ; k++) begin
      waitFlag("t2");
      tick();
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("t2_done", 32'(done), 32'(1 << k));
    end
    check("t2_pending_clr", 32'(pending), 32'h0);
    waitIdle("t2");

    // 3: no ack, timeout 9 cycles after flag
    req = 4'b0100;
    expQ.push_back(2'd2);
    tick();
    req = '0;
    waitFlag("t3");
    n = 0;
    doneSeen = '0;
    while (tmo !== 1'b1 && n < 15) begin
      tick();
      n++;
      doneSeen |= done;
    end
    check("t3_tmo_delay", 32'(n), 32'd9);
    check("t3_no_done", 32'(doneSeen), 32'h0);
    check("t3_pending_clr", 32'(pending[2]), 32'd0);
    waitIdle("t3");

    // 4: ack coincides with expiry, then a spurious ack in GAP
    req = 4'b0001;
    expQ.push_back(2'd0);
    tick();
    req = '0;
    waitFlag("t4");
    for (int k = 0; k < 8; k++) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t4_done_wins", 32'(done), 32'h1);
    check("t4_no_tmo", 32'(tmo), 32'd0);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t4_gap_ack_done", 32'(done), 32'h0);
    check("t4_gap_ack_busy", 32'(busy), 32'd1);
`ifdef FLAG_XFER_STATS_EN
    check("t4_spur_cnt", 32'(spurCnt), 32'd1);
    check("t4_tmo_cnt", 32'(tmoCnt), 32'd1);
`endif
    waitIdle("t4");

    // 5: client 1 re-requests in the cycle its ack arrives
    req = 4'b0010;
    expQ.push_back(2'd1);
    tick();
    req = '0;
    waitFlag("t5a");
    tick();
    tick();
    req = 4'b0010;
    ack = 1'b1;
    expQ.push_back(2'd1);
    tick();
    req = '0;
    ack = 1'b0;
    check("t5_done", 32'(done), 32'h2);
    check("t5_pending_kept", 32'(pending), 32'h2);
    waitFlag("t5b");
    tick();
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t5_done2", 32'(done), 32'h2);
    check("t5_pending_clr", 32'(pending), 32'h0);
    waitIdle("t5");

    // 6: reset during WAIT_ACK, then a stale ack
    req = 4'b1000;
    expQ.push_back(2'd3);
    tick();
    req = '0;
    waitFlag("t6");
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_sel", 32'(sel), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    doneSeen = '0;
    flagSeen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      doneSeen |= done;
      flagSeen |= flag;
      tick();
    end
    check("t6_no_done", 32'(doneSeen), 32'h0);
    check("t6_no_flag", 32'(flagSeen), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_pending", 32'(pending), 32'h0);
    check("sb_drained", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
